// File: rtl/sha256_axil_regs_if.sv
// AXI4-Lite (no resp/prot) bus bundle between the CPU-side master and the
// SHA-256 register slave.
interface sha256_axil_regs_if;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid;
  logic        s_bready;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    input  s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
  );

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    output s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
  );
endinterface

// File: rtl/sha256_axil_regs.sv
// AXI4-Lite register front end for the SHA-256 core: buffers one 512-bit block,
// launches compressions and holds the last 256-bit digest for readback.
module sha256_axil_regs #(
  parameter int ADDR_LSB_W = 8
) (
  input  logic                clk,
  input  logic                resetn,
  sha256_axil_regs_if.slave   s,
  output logic                core_start,
  output logic                core_init,
  output logic [511:0]        core_block,
  input  logic                core_done,
  input  logic [255:0]        core_digest,
  output logic                irq_done
);
  localparam int WW = ADDR_LSB_W - 2;

  logic          aw_held_q, aw_held_d;
  logic [WW-1:0] aw_word_q, aw_word_d;
  logic          w_held_q, w_held_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   msg_q [16];
  logic [31:0]   msg_d [16];
  logic [31:0]   dig_q [8];
  logic [31:0]   dig_d [8];
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          ie_q, ie_d;
  logic          start_q, start_d;
  logic          init_q, init_d;

  logic          do_write;
  logic [WW-1:0] ar_word;
  logic [31:0]   rd_val;
  logic          unused_addr_bits;

  function automatic logic is_msg(input logic [WW-1:0] w);
    return w[WW-1:4] == (WW-4)'(1);
  endfunction

  function automatic logic is_dig(input logic [WW-1:0] w);
    return w[WW-1:3] == (WW-3)'(4);
  endfunction

  assign s.s_awready = !aw_held_q && !bvalid_q;
  assign s.s_wready  = !w_held_q && !bvalid_q;
  assign s.s_bvalid  = bvalid_q;
  assign s.s_arready = !rvalid_q;
  assign s.s_rvalid  = rvalid_q;
  assign s.s_rdata   = rdata_q;

  assign core_start = start_q;
  assign core_init  = init_q;
  assign irq_done   = done_q && ie_q;

  // Upper bits are consumed by the upstream decoder; the low two select bytes.
  assign unused_addr_bits = ^{s.s_awaddr[31:ADDR_LSB_W], s.s_awaddr[1:0],
                              s.s_araddr[31:ADDR_LSB_W], s.s_araddr[1:0]};

  assign ar_word  = s.s_araddr[ADDR_LSB_W-1:2];
  assign do_write = aw_held_q && w_held_q && !bvalid_q;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_block
      assign core_block[511-32*gi -: 32] = msg_q[gi];
    end
  endgenerate

  always_comb begin
    rd_val = '0;
    if (ar_word == WW'(1))
      rd_val = {28'd0, ie_q, ovr_q, done_q, busy_q};
    else if (is_msg(ar_word))
      rd_val = msg_q[ar_word[3:0]];
    else if (is_dig(ar_word))
      rd_val = dig_q[ar_word[2:0]];
  end

  always_comb begin
    aw_held_d = aw_held_q;
    aw_word_d = aw_word_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    msg_d     = msg_q;
    dig_d     = dig_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    ie_d      = ie_q;
    start_d   = 1'b0;
    init_d    = init_q;

    if (s.s_awvalid && s.s_awready) begin
      aw_held_d = 1'b1;
      aw_word_d = s.s_awaddr[ADDR_LSB_W-1:2];
    end
    if (s.s_wvalid && s.s_wready) begin
      w_held_d = 1'b1;
      wdata_d  = s.s_wdata;
      wstrb_d  = s.s_wstrb;
    end

    if (do_write) begin
      bvalid_d = 1'b1;
      if (aw_word_q == '0 && wstrb_q[0]) begin
        ie_d = wdata_q[3];
        if (wdata_q[2])
          ovr_d = 1'b0;
        if (wdata_q[0]) begin
          if (busy_q) begin
            ovr_d = 1'b1;
          end else begin
            start_d = 1'b1;
            init_d  = wdata_q[1];
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end else if (is_msg(aw_word_q)) begin
        // The block must not move under the core, so busy writes are dropped.
        if (busy_q) begin
          ovr_d = 1'b1;
        end else begin
          for (int b = 0; b < 4; b++)
            if (wstrb_q[b])
              msg_d[aw_word_q[3:0]][8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end

    if (bvalid_q && s.s_bready) begin
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end

    // A start is only accepted while idle, so this never races with it.
    if (core_done && busy_q) begin
      for (int i = 0; i < 8; i++)
        dig_d[i] = core_digest[255-32*i -: 32];
      busy_d = 1'b0;
      done_d = 1'b1;
    end

    if (s.s_arvalid && s.s_arready) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
    end else if (rvalid_q && s.s_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_held_q <= 1'b0;
      aw_word_q <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      msg_q     <= '{default: '0};
      dig_q     <= '{default: '0};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      ie_q      <= 1'b0;
      start_q   <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_word_q <= aw_word_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      msg_q     <= msg_d;
      dig_q     <= dig_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      ie_q      <= ie_d;
      start_q   <= start_d;
      init_q    <= init_d;
    end
  end
endmodule

// File: tb/tb_sha256_axil_regs.sv
// Directed bench for sha256_axil_regs: a register-level model of the block's
// architectural state is compared every cycle, plus literal spot checks.
module tb_sha256_axil_regs;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         core_start, core_init, core_done, irq_done;
  logic [511:0] core_block;
  logic [255:0] core_digest;

  sha256_axil_regs_if bus();

  sha256_axil_regs #(.ADDR_LSB_W(8)) dut (
    .clk(clk), .resetn(resetn), .s(bus.slave),
    .core_start(core_start), .core_init(core_init), .core_block(core_block),
    .core_done(core_done), .core_digest(core_digest), .irq_done(irq_done)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_B =
    256'h01234567_89abcdef_11111111_22222222_33333333_44444444_55555555_66666666;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Architectural model
  logic [31:0] m_msg [16];
  logic [31:0] m_dig [8];
  logic        m_busy, m_done, m_ovr, m_ie, m_init;
  int          m_start_cyc = -1;
  int          start_seen = 0;
  bit          cmp_en = 0;
  logic [511:0] exp_blk;
  logic [31:0]  got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_msg[i] = '0;
    for (int i = 0; i < 8; i++) m_dig[i] = '0;
    m_busy = 0; m_done = 0; m_ovr = 0; m_ie = 0; m_init = 0;
    m_start_cyc = -1;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] st);
    int off;
    off = int'(a[7:0]);
    if (off < 4) begin
      if (st[0]) begin
        m_ie = d[3];
        if (d[2]) m_ovr = 0;
        if (d[0]) begin
          if (m_busy) m_ovr = 1;
          else begin
            m_busy = 1; m_done = 0; m_init = d[1]; m_start_cyc = cyc;
          end
        end
      end
    end else if (off >= 'h40 && off < 'h80) begin
      if (m_busy) m_ovr = 1;
      else
        for (int b = 0; b < 4; b++)
          if (st[b]) m_msg[(off - 'h40) / 4][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int off;
    off = int'(a[7:0]);
    if (off >= 4 && off < 8) return {28'd0, m_ie, m_ovr, m_done, m_busy};
    if (off >= 'h40 && off < 'h80) return m_msg[(off - 'h40) / 4];
    if (off >= 'h80 && off < 'hA0) return m_dig[(off - 'h80) / 4];
    return 32'd0;
  endfunction

  function automatic void model_done(input logic [255:0] dg);
    if (m_busy) begin
      for (int i = 0; i < 8; i++) m_dig[i] = dg[255-32*i -: 32];
      m_busy = 0; m_done = 1;
    end
  endfunction

  // Per-cycle comparison of core-side outputs against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en && resetn) begin
      for (int i = 0; i < 16; i++) exp_blk[511-32*i -: 32] = m_msg[i];
      checks++;
      if (core_block !== exp_blk) begin
        errors++;
        $display("FAIL core_block: got %h expected %h", core_block, exp_blk);
      end
      chk("irq_done", 32'(irq_done), 32'(m_done & m_ie));
      chk("core_start", 32'(core_start), 32'(cyc == m_start_cyc));
      if (core_start) begin
        start_seen++;
        chk("core_init", 32'(core_init), 32'(m_init));
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    int t = 0;
    int aw_at = -1;
    int w_at = -2;
    bit aw_hs, w_hs;
    bus.s_awvalid = 1; bus.s_awaddr = a;
    bus.s_wvalid = 1;  bus.s_wdata = d; bus.s_wstrb = st;
    while (bus.s_awvalid || bus.s_wvalid) begin
      @(negedge clk);
      aw_hs = bus.s_awvalid && bus.s_awready;
      w_hs  = bus.s_wvalid && bus.s_wready;
      @(posedge clk); #1;
      if (aw_hs) begin bus.s_awvalid = 0; aw_at = cyc; end
      if (w_hs)  begin bus.s_wvalid = 0;  w_at = cyc; end
      if (++t > 100) begin
        chk("timeout_aw_w", 32'(t), 32'd0);
        bus.s_awvalid = 0; bus.s_wvalid = 0;
        return;
      end
    end
    t = 0;
    while (!bus.s_bvalid) begin
      @(posedge clk); #1;
      if (++t > 100) begin chk("timeout_b", 32'(t), 32'd0); return; end
    end
    model_write(a, d, st);
    if (aw_at == w_at) chk("b_latency", 32'(cyc - aw_at), 32'd1);
  endtask

  task automatic axi_read(input string name, input logic [31:0] a, output logic [31:0] val);
    logic [31:0] exp = '0;
    int t = 0;
    bit hs = 0;
    bus.s_arvalid = 1; bus.s_araddr = a;
    while (!hs) begin
      @(negedge clk);
      hs = bus.s_arready;
      if (hs) exp = model_read(a);
      @(posedge clk); #1;
      if (++t > 100) begin chk("timeout_ar", 32'(t), 32'd0); break; end
    end
    bus.s_arvalid = 0;
    chk({name, "_rvalid"}, 32'(bus.s_rvalid), 32'd1);
    @(negedge clk);
    chk(name, bus.s_rdata, exp);
    val = bus.s_rdata;
    @(posedge clk); #1;
  endtask

  task automatic pulse_done(input logic [255:0] dg);
    core_done = 1; core_digest = dg;
    @(posedge clk); #1;
    core_done = 0;
    model_done(dg);
  endtask

  initial begin
    bus.s_awvalid = 0; bus.s_awaddr = '0; bus.s_wvalid = 0; bus.s_wdata = '0;
    bus.s_wstrb = '0; bus.s_bready = 1; bus.s_arvalid = 0; bus.s_araddr = '0;
    bus.s_rready = 1; core_done = 0; core_digest = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 resetn = 1;

    chk("rst_awready", 32'(bus.s_awready), 32'd1);
    chk("rst_wready", 32'(bus.s_wready), 32'd1);
    chk("rst_arready", 32'(bus.s_arready), 32'd1);
    chk("rst_bvalid", 32'(bus.s_bvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.s_rvalid), 32'd0);
    chk("rst_rdata", bus.s_rdata, 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_core_init", 32'(core_init), 32'd0);
    chk("rst_irq", 32'(irq_done), 32'd0);
    cmp_en = 1;

    axi_read("rst_status", 32'h04, got); chk("rst_status_lit", got, 32'h0);
    axi_read("rst_dig0", 32'h80, got);   chk("rst_dig0_lit", got, 32'h0);

    // "abc" single block
    for (int i = 0; i < 16; i++)
      axi_write(32'h40 + 32'(4*i), (i == 0) ? 32'h61626380 : (i == 15) ? 32'h18 : 32'h0, 4'hF);
    start_seen = 0;
    axi_write(32'h00, 32'h3, 4'hF);
    axi_read("busy_status", 32'h04, got); chk("busy_status_lit", got, 32'h1);
    repeat (60) begin @(posedge clk); #1; end
    chk("start_pulses", 32'(start_seen), 32'd1);
    pulse_done(ABC_DIG);
    axi_read("done_status", 32'h04, got); chk("done_status_lit", got, 32'h2);
    axi_read("dig0", 32'h80, got);        chk("dig0_lit", got, 32'hBA7816BF);
    axi_read("dig7", 32'h9C, got);        chk("dig7_lit", got, 32'hF20015AD);
    axi_read("dig3", 32'h8C, got);

    // Overrun while busy
    axi_write(32'h00, 32'h3, 4'hF);
    axi_write(32'h00, 32'h1, 4'hF);
    axi_write(32'h4C, 32'hDEADBEEF, 4'hF);
    axi_read("ovr_status", 32'h04, got); chk("ovr_status_lit", got, 32'h5);
    axi_read("ovr_msg3", 32'h4C, got);   chk("ovr_msg3_lit", got, 32'h0);
    axi_write(32'h00, 32'h4, 4'hF);
    axi_read("clr_status", 32'h04, got); chk("clr_status_lit", got, 32'h1);
    pulse_done(DIG_B);
    axi_read("digb0", 32'h80, got);      chk("digb0_lit", got, 32'h01234567);

    // Done while idle is ignored
    pulse_done({8{32'hFFFFFFFF}});
    axi_read("idle_dig0", 32'h80, got);  chk("idle_dig0_lit", got, 32'h01234567);

    // Byte strobes and unmapped offsets
    axi_write(32'h54, 32'hFFFFFFFF, 4'hF);
    axi_write(32'h54, 32'h00001234, 4'b0011);
    axi_read("msg5", 32'h54, got);       chk("msg5_lit", got, 32'hFFFF1234);
    axi_write(32'h20, 32'h12345678, 4'hF);
    axi_read("unmapped", 32'h20, got);   chk("unmapped_lit", got, 32'h0);
    axi_read("ctrl_rd", 32'h00, got);    chk("ctrl_rd_lit", got, 32'h0);
    axi_write(32'h80, 32'hCAFEF00D, 4'hF);
    axi_read("dig_ro", 32'h80, got);     chk("dig_ro_lit", got, 32'h01234567);

    // Back-pressure on B and R
    bus.s_bready = 0; bus.s_rready = 0;
    axi_write(32'h44, 32'hA5A50001, 4'hF);
    axi_read("hold_rd", 32'h44, got);    chk("hold_rd_lit", got, 32'hA5A50001);
    repeat (5) begin
      @(negedge clk);
      chk("hold_bvalid", 32'(bus.s_bvalid), 32'd1);
      chk("hold_rvalid", 32'(bus.s_rvalid), 32'd1);
      chk("hold_rdata", bus.s_rdata, 32'hA5A50001);
      chk("hold_awready", 32'(bus.s_awready), 32'd0);
      chk("hold_wready", 32'(bus.s_wready), 32'd0);
      chk("hold_arready", 32'(bus.s_arready), 32'd0);
      @(posedge clk); #1;
    end
    bus.s_bready = 1; bus.s_rready = 1;
    @(posedge clk); #1;

    // AW one cycle ahead of W
    bus.s_awvalid = 1; bus.s_awaddr = 32'h48;
    @(negedge clk); chk("split_awready", 32'(bus.s_awready), 32'd1);
    @(posedge clk); #1;
    bus.s_awvalid = 0;
    bus.s_wvalid = 1; bus.s_wdata = 32'h0BADF00D; bus.s_wstrb = 4'hF;
    @(negedge clk); chk("split_wready", 32'(bus.s_wready), 32'd1);
    @(posedge clk); #1;
    bus.s_wvalid = 0;
    chk("split_b_early", 32'(bus.s_bvalid), 32'd0);
    @(posedge clk); #1;
    chk("split_b", 32'(bus.s_bvalid), 32'd1);
    model_write(32'h48, 32'h0BADF00D, 4'hF);
    @(posedge clk); #1;
    chk("split_b_drop", 32'(bus.s_bvalid), 32'd0);
    @(posedge clk); #1;
    chk("split_b_single", 32'(bus.s_bvalid), 32'd0);
    axi_read("split_msg2", 32'h48, got); chk("split_msg2_lit", got, 32'h0BADF00D);

    // Interrupt, then reset mid-compression
    axi_write(32'h00, 32'h9, 4'hF);
    repeat (10) begin @(posedge clk); #1; end
    pulse_done(ABC_DIG);
    chk("irq_set", 32'(irq_done), 32'd1);
    axi_write(32'h00, 32'h9, 4'hF);
    chk("irq_clr", 32'(irq_done), 32'd0);
    repeat (5) begin @(posedge clk); #1; end
    cmp_en = 0;
    resetn = 0;
    repeat (2) begin @(posedge clk); #1; end
    resetn = 1;
    model_reset();
    cmp_en = 1;
    axi_read("rst2_status", 32'h04, got); chk("rst2_status_lit", got, 32'h0);
    axi_read("rst2_msg0", 32'h40, got);   chk("rst2_msg0_lit", got, 32'h0);
    chk("rst2_irq", 32'(irq_done), 32'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_axil_regs.md
# sha256_axil_regs

AXI4-Lite register slave that exposes the SHA-256 core to the picorv32 `mem_axi_*` bus. It sits directly downstream of the CPU's AXI master, beside `axi4_mem_periph`, after the address decoder. It buffers one 512-bit message block, launches the core, and captures the 256-bit digest into read-only registers. It also raises a level interrupt that firmware can route to `irq`.

## Interface
- `ADDR_LSB_W`, default 8: number of low address bits decoded. Bits above this are ignored, because upstream decode selects this slave.
- `clk`  in  1  clock; all logic rises on the posedge.
- `resetn`  in  1  reset, synchronous, active-low.
- `s_awvalid` in 1 / `s_awready` out 1 / `s_awaddr` in 32: write-address channel. `awprot` is not connected.
- `s_wvalid` in 1 / `s_wready` out 1 / `s_wdata` in 32 / `s_wstrb` in 4: write-data channel.
- `s_bvalid` out 1 / `s_bready` in 1: write response. There is no resp field.
- `s_arvalid` in 1 / `s_arready` out 1 / `s_araddr` in 32: read-address channel.
- `s_rvalid` out 1 / `s_rready` in 1 / `s_rdata` out 32: read data.
- `core_start`  out  1  one-cycle pulse that launches one compression.
- `core_init`  out  1  stable with `core_start`; 1 means load the H0 IV before the compression.
- `core_block`  out  512  message block. `MSG[0]` drives bits [511:480].
- `core_done`  in  1  one-cycle pulse; `core_digest` is valid in the same cycle.
- `core_digest`  in  256  `DIG[0]` is bits [255:224].
- `irq_done`  out  1  level interrupt, equal to `DONE & IE`.

## Operation
- Address map, word offsets taken from `addr[ADDR_LSB_W-1:0]`:
  - 0x00 CTRL, write-only, reads as 0. Bit0 START, bit1 INIT, bit2 CLR_OVR, bit3 IE; IE is stored.
  - 0x04 STATUS, read-only. Bit0 BUSY, bit1 DONE, bit2 OVR, bit3 IE.
  - 0x40–0x7C MSG[0..15], read/write.
  - 0x80–0x9C DIG[0..7], read-only.
  - All other offsets read as 0, and writes to them are ignored.
- Writes to MSG honour `wstrb` per byte. CTRL bits act only when `wstrb[0]=1`.
- START=1 while BUSY=0:
  - `core_start` pulses on the next cycle, with `core_init` equal to the written INIT bit.
  - BUSY goes to 1 and DONE goes to 0.
- START=1 while BUSY=1: ignored, and OVR is set.
- A MSG write while BUSY=1: dropped, so `core_block` stays stable for the whole compression, and OVR is set.
- OVR is sticky. It clears only on a CTRL write with CLR_OVR=1.
- On `core_done`, all in one edge: DIG[0..7] takes `core_digest`, BUSY goes to 0, and DONE goes to 1.
- DONE stays at 1 until the next accepted START.
- DIG registers keep their last digest until the next `core_done`, including while BUSY=1.
- `core_done` while BUSY=0 is ignored; DIG is not updated.
- A multi-block message is sent as follows: first block with INIT=1, later blocks with INIT=0. The core chains the state internally.

## Timing
- Reset values:
  - All `s_*valid` outputs are 0. `s_awready`, `s_wready` and `s_arready` are 1.
  - `s_rdata` is 0.
  - `core_start` is 0, `core_init` is 0, and `core_block` is 0.
  - MSG, DIG, BUSY, DONE, OVR and IE are all 0, so `irq_done` is 0.
- Write path:
  - AW and W are accepted independently. Each is latched into a hold register.
  - `s_awready = !aw_held & !s_bvalid`, and `s_wready = !w_held & !s_bvalid`. Both are combinational from registers.
  - When both are held, the register update and `s_bvalid=1` happen on the next edge.
  - `s_bvalid` holds until `s_bready`, then the holds clear.
  - With AW and W arriving in the same cycle and `bready` tied high, the response comes 1 cycle after acceptance.
- Read path:
  - `s_arready = !s_rvalid`.
  - On an AR handshake, `s_rdata` is registered and `s_rvalid=1` on the next edge. Both hold until `s_rready`.
  - The read returns the register state at the AR handshake edge.
- START write accepted at edge N: the register update happens at N+1, and `core_start=1` during cycle N+1 only. BUSY reads 1 from N+1.
- `core_done` and an accepted START on the same edge: START is evaluated against BUSY=1, so it is rejected and sets OVR. The digest is still captured.
- Reset mid-operation returns the block to reset state:
  - BUSY is cleared and a pending B or R response is dropped.
  - The core must be reset by the same `resetn`.

## Test plan
- Reset, then read STATUS → `rdata=0`, one cycle after the AR handshake. Read DIG[0] → 0.
- Write MSG[0..15] with the padded "abc" block (0x61626380, fourteen words of 0, 0x00000018). Write CTRL=0x3. Model `core_done` 64 cycles later with the "abc" digest.
  - Required: `core_start` pulses exactly once with `core_init=1`, and STATUS reads 0x1 while busy.
  - Then STATUS=0x2 and DIG[0]=0xBA7816BF, DIG[7]=0xF20015AD.
- While busy: write START again, then write MSG[3]=0xDEADBEEF → `core_block` unchanged, STATUS bit2=1. Then CTRL=0x4 (CLR_OVR) → bit2 clears.
- Write MSG[5]=0xFFFFFFFF, then MSG[5]=0x00001234 with `wstrb=0011` → MSG[5] reads 0xFFFF1234.
- Hold `bready=0` and `rready=0` for 5 cycles:
  - Required: `bvalid` and `rvalid` stay high with stable data, and `awready`, `wready` and `arready` stay 0.
  - Present AW one cycle before W → a single B response follows W by 1 cycle.
- CTRL=0x9 (IE+START), then `core_done` → `irq_done=1`. Next START → `irq_done=0`. Assert `resetn=0` mid-compression → STATUS=0.
